pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake, optional skid slot,
//  hazard flush and a stall counter. Replaces the fixed-field D->E latch and is instantiated
//  between every stage pair (F/D, D/E, E/M, M/W). Payload is one packed bus. Upstream packs
//  IR, PC4, PC8, RS, RT and EXT into it. An empty stage always presents the bubble payload.
// PARAMETERS
//  DATA_W       192             payload width in bits
//  BUBBLE       {IR=0,PC4=32'h3004,PC8=32'h3008,RS=0,RT=0,EXT=0}  payload driven when empty
//  SKID_EN      1               1 = two-entry skid buffer (registered in_ready); 0 = single entry
//  STALL_CNT_W  16              width of the saturating stall counter
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-low reset (sampled at posedge clk)
//  flush        in   1        synchronous bubble insert; discards all held and incoming entries
//  in_valid     in   1        upstream has payload
//  in_ready     out  1        stage can accept; transfer when in_valid&in_ready
//  in_data      in   DATA_W   upstream payload
//  out_valid    out  1        out_data holds a real instruction
//  out_ready    in   1        downstream accepts; transfer when out_valid&out_ready
//  out_data     out  DATA_W   held payload; equals BUBBLE whenever out_valid=0
//  stall_cnt    out  STALL_CNT_W  cycles with out_valid&~out_ready, saturating
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=EMPTY, out_valid=0, out_data=BUBBLE, skid=BUBBLE,
//   in_ready=1, stall_cnt=0. Reset overrides flush and all handshakes.
//  in_fire=in_valid&in_ready; out_fire=out_valid&out_ready. All updates occur at posedge clk.
//  Latency: one cycle from in_fire to out_valid. Throughput: 1/cycle when out_ready=1.
//  States (SKID_EN=1): EMPTY, FULL (main valid), SKID (main+skid valid).
//   EMPTY: in_fire -> FULL, main<=in_data.
//   FULL : in_fire&out_fire -> FULL, main<=in_data. in_fire&~out_fire -> SKID, skid<=in_data.
//          ~in_fire&out_fire -> EMPTY, main<=BUBBLE. Neither -> FULL, hold.
//   SKID : out_fire -> FULL, main<=skid, skid<=BUBBLE. Else hold. in_ready=0 in SKID.
//   in_ready is registered: 1 in EMPTY/FULL, 0 in SKID. No combinational path out_ready->in_ready.
//  SKID_EN=0: states EMPTY/FULL only. in_ready = ~out_valid | out_ready (combinational).
//   A FULL&in_fire&~out_fire condition cannot occur.
//  flush=1 (reset high): next state EMPTY, main/skid<=BUBBLE, out_valid<=0. Overrides in_fire,
//   out_fire and hold. Incoming payload is dropped; the handshake still completes as seen upstream.
//   The hazard unit flushes upstream stages in the same cycle.
//  Hold (stall): out_ready=0 keeps main bit-exact; out_data never changes while out_valid&~out_ready.
//  Order is preserved: skid entry always follows main entry.
//  stall_cnt: +1 per cycle with out_valid&~out_ready. Saturates at 2^STALL_CNT_W-1 and does not wrap.
//   Cleared only by reset, not by flush.
//  Entries never duplicate or drop except through flush.
// STRUCTURE
//  Package pipe_pkg holds: stage_state_t enum {EMPTY,FULL,SKID}; PIPE_BUBBLE_DE constant;
//   field offset localparams (IR/PC4/PC8/RS/RT/EXT); reset PC constants 32'h3004/32'h3008.
//  Sub-module pipe_skid_slot: one payload register with load/clear-to-BUBBLE. It is instantiated
//   twice (main, skid), and skid is omitted when SKID_EN=0.
//  FSM, handshake logic and stall counter sit in the top module.
// TESTING
//  1 Reset: drive reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=BUBBLE
//    (PC4 field 32'h3004), in_ready=1, stall_cnt=0.
//  2 Streaming: out_ready=1, push IR 32'h8C010004..+4 every cycle -> each appears one cycle later,
//    in_ready stays 1, stall_cnt stays 0.
//  3 Skid: SKID_EN=1, FULL with A, out_ready=0, push B -> SKID, in_ready=0, out_data=A held.
//    out_ready=1 -> A then B delivered in order, in_ready=1 again.
//  4 Flush: state SKID with A,B, flush=1 with in_valid=1 (C) -> next cycle out_valid=0,
//    out_data=BUBBLE, C dropped, state EMPTY.
//  5 Counter saturation: STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles ->
//    stall_cnt=15; flush leaves it 15; reset gives 0.
//  6 SKID_EN=0: FULL, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 ->
//    back-to-back transfer, no bubble cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// The payload is six 32-bit fields packed as {EXT, RT, RS, PC8, PC4, IR}.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    localparam int PIPE_DATA_W = 192;
    localparam int FIELD_W     = 32;
    localparam int IR_LSB      = 0;
    localparam int PC4_LSB     = 32;
    localparam int PC8_LSB     = 64;
    localparam int RS_LSB      = 96;
    localparam int RT_LSB      = 128;
    localparam int EXT_LSB     = 160;

    localparam logic [FIELD_W-1:0] RESET_PC4 = 32'h0000_3004;
    localparam logic [FIELD_W-1:0] RESET_PC8 = 32'h0000_3008;

    localparam logic [PIPE_DATA_W-1:0] PIPE_BUBBLE_DE =
        {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, RESET_PC8, RESET_PC4, 32'h0000_0000};

    function automatic logic [FIELD_W-1:0] get_field(input logic [PIPE_DATA_W-1:0] data,
                                                     input int lsb);
        return data[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register of a pipeline stage; load takes new data, clear
// (or reset) returns it to the bubble payload.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE = PIPE_BUBBLE_DE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_r;

    // Payload register: clear wins over load so a flush always leaves a bubble.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r <= BUBBLE;
        end else if (clear) begin
            data_r <= BUBBLE;
        end else if (load) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional skid entry,
// flush to bubble and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE      = PIPE_BUBBLE_DE,
    parameter bit                 SKID_EN     = 1'b1,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_state_t            state_r, state_next_s;
    logic                    out_valid_r, in_ready_r;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic                    in_fire_s, out_fire_s;
    logic                    main_load_s, main_clear_s, skid_load_s, skid_clear_s;
    logic [DATA_W-1:0]       main_d_s, main_q_s, skid_q_s;

    // With SKID_EN=0 in_ready_r mirrors "stage empty" and out_ready adds the pass-through term.
    assign in_ready   = in_ready_r | (!SKID_EN && out_ready);
    assign out_valid  = out_valid_r;
    assign out_data   = main_q_s;
    assign stall_cnt  = stall_cnt_r;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid_r && out_ready;

    // State register with registered valid/ready flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s != EMPTY);
            in_ready_r  <= SKID_EN ? (state_next_s != SKID) : (state_next_s == EMPTY);
        end
    end

    // Next-state logic; flush forces EMPTY regardless of handshakes.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: state_next_s = in_fire_s ? FULL : EMPTY;
                FULL: begin
                    if (in_fire_s && !out_fire_s && SKID_EN) begin
                        state_next_s = SKID;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_next_s = EMPTY;
                    end else begin
                        state_next_s = FULL;
                    end
                end
                SKID:    state_next_s = out_fire_s ? FULL : SKID;
                default: state_next_s = EMPTY;
            endcase
        end
    end

    // Payload slot controls for the current state and handshake outcome.
    always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        main_d_s     = in_data;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (flush) begin
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else begin
            case (state_r)
                EMPTY: main_load_s = in_fire_s;
                FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                    end else if (in_fire_s) begin
                        skid_load_s = 1'b1;
                    end else if (out_fire_s) begin
                        main_clear_s = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                SKID: begin
                    if (out_fire_s) begin
                        main_load_s  = 1'b1;
                        main_d_s     = skid_q_s;
                        skid_clear_s = 1'b1;
                    end else begin
                        main_load_s = 1'b0;
                    end
                end
                default: main_clear_s = 1'b1;
            endcase
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    pipe_skid_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load_s),
        .clear (main_clear_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_skid_slot #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
                .clk   (clk),
                .reset (reset),
                .load  (skid_load_s),
                .clear (skid_clear_s),
                .d     (in_data),
                .q     (skid_q_s)
            );
        end else begin : g_no_skid
            assign skid_q_s = BUBBLE;
        end
    endgenerate

endmodule
